// File: rtl/pseudo_random_pkg.sv
// Shared constants for the pseudo-random generators: maximal-length tap masks and default seed.
package pseudo_random_pkg;

  localparam int unsigned MIN_WIDTH    = 3;
  localparam int unsigned MAX_WIDTH    = 16;
  localparam int unsigned DEFAULT_SEED = 1;

  // Bit i set means state[i] feeds the XOR; TAPS_3 reproduces the legacy 3-bit generator.
  localparam logic [2:0]  TAPS_3  = 3'b101;
  localparam logic [3:0]  TAPS_4  = 4'hC;
  localparam logic [4:0]  TAPS_5  = 5'h14;
  localparam logic [5:0]  TAPS_6  = 6'h30;
  localparam logic [6:0]  TAPS_7  = 7'h60;
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [8:0]  TAPS_9  = 9'h110;
  localparam logic [9:0]  TAPS_10 = 10'h240;
  localparam logic [10:0] TAPS_11 = 11'h500;
  localparam logic [11:0] TAPS_12 = 12'h829;
  localparam logic [12:0] TAPS_13 = 13'h100D;
  localparam logic [13:0] TAPS_14 = 14'h2015;
  localparam logic [14:0] TAPS_15 = 15'h6000;
  localparam logic [15:0] TAPS_16 = 16'hD008;

  // Maximal-length mask for a given width, zero-extended to MAX_WIDTH; 0 for unsupported widths.
  function automatic logic [MAX_WIDTH-1:0] max_taps(input int unsigned width);
    case (width)
      3:       return MAX_WIDTH'(TAPS_3);
      4:       return MAX_WIDTH'(TAPS_4);
      5:       return MAX_WIDTH'(TAPS_5);
      6:       return MAX_WIDTH'(TAPS_6);
      7:       return MAX_WIDTH'(TAPS_7);
      8:       return MAX_WIDTH'(TAPS_8);
      9:       return MAX_WIDTH'(TAPS_9);
      10:      return MAX_WIDTH'(TAPS_10);
      11:      return MAX_WIDTH'(TAPS_11);
      12:      return MAX_WIDTH'(TAPS_12);
      13:      return MAX_WIDTH'(TAPS_13);
      14:      return MAX_WIDTH'(TAPS_14);
      15:      return MAX_WIDTH'(TAPS_15);
      16:      return TAPS_16;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// One Fibonacci LFSR step: shift toward the MSB, XOR of tapped bits enters bit 0.
module lfsr_step
  import pseudo_random_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_8)
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next_state_c
);

  assign next_state_c = {state[WIDTH-2:0], ^(state & TAPS)};

endmodule

// File: rtl/lfsr_prng.sv
// LFSR random-word source with valid/ready output, runtime seed load, zero-seed
// lockup protection and measurement of the period relative to the active seed.
module lfsr_prng
  import pseudo_random_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_8),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clk_pseudo_random,
  input  logic             reset_pseudo_random,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] rnd_data,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic             lockup_fix,
  output logic             period_wrap,
  output logic [WIDTH-1:0] period_len
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] active_seed_q, active_seed_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_len_d;
  logic             rnd_valid_d, lockup_fix_d, period_wrap_d;
  logic [WIDTH-1:0] step_c;
  logic             fire_c;

  lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step (
    .state        (state_q),
    .next_state_c (step_c)
  );

  assign fire_c   = rnd_valid & rnd_ready;
  assign rnd_data = state_q;

  // Next-state: load beats fire, fire beats the initial offer.
  always_comb begin
    state_d       = state_q;
    active_seed_d = active_seed_q;
    count_d       = count_q;
    period_len_d  = period_len;
    rnd_valid_d   = rnd_valid;
    lockup_fix_d  = 1'b0;
    period_wrap_d = 1'b0;

    if (load) begin
      // A zero seed would lock the register at zero forever, so fall back to SEED.
      if (seed_in == '0) begin
        state_d       = SEED;
        active_seed_d = SEED;
        lockup_fix_d  = 1'b1;
      end else begin
        state_d       = seed_in;
        active_seed_d = seed_in;
      end
      rnd_valid_d  = 1'b0;
      count_d      = '0;
      period_len_d = '0;
    end else if (fire_c) begin
      state_d     = step_c;
      rnd_valid_d = en;
      if (step_c == active_seed_q) begin
        period_wrap_d = 1'b1;
        period_len_d  = count_q + WIDTH'(1);
        count_d       = '0;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end else if (!rnd_valid && en) begin
      rnd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_pseudo_random or negedge reset_pseudo_random) begin
    if (!reset_pseudo_random) begin
      state_q       <= SEED;
      active_seed_q <= SEED;
      count_q       <= '0;
      period_len    <= '0;
      rnd_valid     <= 1'b0;
      lockup_fix    <= 1'b0;
      period_wrap   <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_seed_q <= active_seed_d;
      count_q       <= count_d;
      period_len    <= period_len_d;
      rnd_valid     <= rnd_valid_d;
      lockup_fix    <= lockup_fix_d;
      period_wrap   <= period_wrap_d;
    end
  end

endmodule

// File: tb/tb_lfsr_prng.sv
// Bench for lfsr_prng: 3-bit and default 8-bit instances driven together and
// checked every cycle against a behavioural model, plus literal sequence checks.
module tb_lfsr_prng;

  logic       clk_pseudo_random   = 1'b0;
  logic       reset_pseudo_random = 1'b0;
  logic       en        = 1'b0;
  logic       load      = 1'b0;
  logic       rnd_ready = 1'b0;
  logic [2:0] seed3     = 3'd0;
  logic [7:0] seed8     = 8'd0;

  logic [2:0] rnd_data3, period_len3;
  logic       rnd_valid3, lockup_fix3, period_wrap3;
  logic [7:0] rnd_data8, period_len8;
  logic       rnd_valid8, lockup_fix8, period_wrap8;

  int tests = 0;
  int fails = 0;
  int wraps3 = 0;
  int wraps8 = 0;

  always #5 clk_pseudo_random = ~clk_pseudo_random;

  lfsr_prng #(.WIDTH(3), .TAPS(3'b101), .SEED(3'd1)) u3 (
    .clk_pseudo_random   (clk_pseudo_random),
    .reset_pseudo_random (reset_pseudo_random),
    .en                  (en),
    .load                (load),
    .seed_in             (seed3),
    .rnd_data            (rnd_data3),
    .rnd_valid           (rnd_valid3),
    .rnd_ready           (rnd_ready),
    .lockup_fix          (lockup_fix3),
    .period_wrap         (period_wrap3),
    .period_len          (period_len3)
  );

  lfsr_prng u8 (
    .clk_pseudo_random   (clk_pseudo_random),
    .reset_pseudo_random (reset_pseudo_random),
    .en                  (en),
    .load                (load),
    .seed_in             (seed8),
    .rnd_data            (rnd_data8),
    .rnd_valid           (rnd_valid8),
    .rnd_ready           (rnd_ready),
    .lockup_fix          (lockup_fix8),
    .period_wrap         (period_wrap8),
    .period_len          (period_len8)
  );

  // Reference step: parity of the tapped bits by counting, then shift left within w bits.
  function automatic logic [15:0] ref_next(input logic [15:0] s, input logic [15:0] taps, input int w);
    int ones = 0;
    for (int i = 0; i < w; i++) if (taps[i] && s[i]) ones++;
    return 16'(((32'(s) << 1) | 32'(ones % 2)) & ((32'd1 << w) - 32'd1));
  endfunction

  function automatic int width_of(input int k);
    return (k == 0) ? 3 : 8;
  endfunction

  function automatic logic [15:0] taps_of(input int k);
    return (k == 0) ? 16'h0005 : 16'h00B8;
  endfunction

  function automatic logic [15:0] seed_of(input int k);
    return (k == 0) ? 16'(seed3) : 16'(seed8);
  endfunction

  // Model state, index 0 = 3-bit instance, 1 = 8-bit instance.
  logic [15:0] m_state[2], m_aseed[2], m_cnt[2], m_len[2];
  logic        m_valid[2], m_lock[2], m_wrap[2];
  logic [15:0] acc3[$];

  always @(posedge clk_pseudo_random or negedge reset_pseudo_random) begin
    if (!reset_pseudo_random) begin
      for (int k = 0; k < 2; k++) begin
        m_state[k] <= 16'd1; m_aseed[k] <= 16'd1; m_cnt[k] <= 16'd0; m_len[k] <= 16'd0;
        m_valid[k] <= 1'b0;  m_lock[k]  <= 1'b0;  m_wrap[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_lock[k] <= 1'b0;
        m_wrap[k] <= 1'b0;
        if (load) begin
          if (seed_of(k) == 16'd0) begin
            m_state[k] <= 16'd1; m_aseed[k] <= 16'd1; m_lock[k] <= 1'b1;
          end else begin
            m_state[k] <= seed_of(k); m_aseed[k] <= seed_of(k);
          end
          m_valid[k] <= 1'b0; m_cnt[k] <= 16'd0; m_len[k] <= 16'd0;
        end else if (m_valid[k] && rnd_ready) begin
          if (k == 0) acc3.push_back(m_state[0]);
          m_state[k] <= ref_next(m_state[k], taps_of(k), width_of(k));
          m_valid[k] <= en;
          if (ref_next(m_state[k], taps_of(k), width_of(k)) == m_aseed[k]) begin
            m_wrap[k] <= 1'b1; m_len[k] <= m_cnt[k] + 16'd1; m_cnt[k] <= 16'd0;
          end else begin
            m_cnt[k] <= m_cnt[k] + 16'd1;
          end
        end else if (!m_valid[k] && en) begin
          m_valid[k] <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model, on the falling edge.
  task automatic compare_all();
    chk("data3",  16'(rnd_data3),    m_state[0]);
    chk("valid3", 16'(rnd_valid3),   16'(m_valid[0]));
    chk("lock3",  16'(lockup_fix3),  16'(m_lock[0]));
    chk("wrap3",  16'(period_wrap3), 16'(m_wrap[0]));
    chk("plen3",  16'(period_len3),  m_len[0]);
    chk("data8",  16'(rnd_data8),    m_state[1]);
    chk("valid8", 16'(rnd_valid8),   16'(m_valid[1]));
    chk("lock8",  16'(lockup_fix8),  16'(m_lock[1]));
    chk("wrap8",  16'(period_wrap8), 16'(m_wrap[1]));
    chk("plen8",  16'(period_len8),  m_len[1]);
    chk("nonzero8", 16'(rnd_data8 != 8'd0), 16'd1);
    wraps3 += int'(period_wrap3);
    wraps8 += int'(period_wrap8);
  endtask

  task automatic tick();
    @(negedge clk_pseudo_random);
    compare_all();
    @(posedge clk_pseudo_random);
    #2;
  endtask

  task automatic wait_acc(input int n, input string name);
    int t = 0;
    while (acc3.size() < n && t < 64) begin
      tick();
      t++;
    end
    chk(name, 16'(acc3.size() >= n), 16'd1);
  endtask

  logic [15:0] exp_a[8];
  logic [15:0] exp_b[8];
  logic [15:0] h;
  int base;

  initial begin
    exp_a = '{16'd1, 16'd3, 16'd7, 16'd6, 16'd5, 16'd2, 16'd4, 16'd1};
    exp_b = '{16'd6, 16'd5, 16'd2, 16'd4, 16'd1, 16'd3, 16'd7, 16'd6};

    // Reset state
    tick(); tick();
    chk("reset_data3", 16'(rnd_data3), 16'd1);
    chk("reset_valid3", 16'(rnd_valid3), 16'd0);
    chk("reset_plen8", 16'(period_len8), 16'd0);

    // 3-bit sequence after release and 8-bit free run
    reset_pseudo_random = 1'b1; en = 1'b1; rnd_ready = 1'b1;
    base = acc3.size(); wraps3 = 0; wraps8 = 0;
    wait_acc(base + 8, "seq_timeout");
    if (acc3.size() >= base + 8)
      for (int i = 0; i < 8; i++) chk("seq_after_reset", acc3[base+i], exp_a[i]);
    chk("wraps3_first_period", 16'(wraps3), 16'd1);
    chk("plen3_first_period", 16'(period_len3), 16'd7);
    repeat (600) tick();
    chk("wraps8_count", 16'(wraps8), 16'd2);
    chk("plen8_max", 16'(period_len8), 16'd255);

    // Backpressure: word must hold, then resume without skipping
    rnd_ready = 1'b0;
    tick();
    h = m_state[0];
    repeat (5) begin
      tick();
      chk("stall_data3", 16'(rnd_data3), h);
      chk("stall_valid3", 16'(rnd_valid3), 16'd1);
    end
    base = acc3.size(); rnd_ready = 1'b1;
    wait_acc(base + 2, "resume_timeout");
    if (acc3.size() >= base + 2) begin
      chk("resume_word0", acc3[base], h);
      chk("resume_word1", acc3[base+1], ref_next(h, 16'h0005, 3));
    end

    // Zero seed replaced by SEED with a one-cycle lockup pulse
    seed3 = 3'd0; seed8 = 8'd0; load = 1'b1;
    tick();
    load = 1'b0;
    chk("lock3_pulse", 16'(lockup_fix3), 16'd1);
    chk("lock8_pulse", 16'(lockup_fix8), 16'd1);
    chk("lock_valid3", 16'(rnd_valid3), 16'd0);
    chk("lock_data3", 16'(rnd_data3), 16'd1);
    tick();
    chk("lock3_end", 16'(lockup_fix3), 16'd0);
    chk("lock_offer3", 16'(rnd_valid3), 16'd1);
    chk("lock_word3", 16'(rnd_data3), 16'd1);

    // Load colliding with a fire: fire discarded, period measured from seed 6
    tick();
    seed3 = 3'd6; seed8 = 8'h5A; load = 1'b1; base = acc3.size();
    tick();
    load = 1'b0; wraps3 = 0;
    chk("load6_valid3", 16'(rnd_valid3), 16'd0);
    chk("load6_lock3", 16'(lockup_fix3), 16'd0);
    wait_acc(base + 8, "seed6_timeout");
    if (acc3.size() >= base + 8)
      for (int i = 0; i < 8; i++) chk("seq_seed6", acc3[base+i], exp_b[i]);
    chk("wraps3_seed6", 16'(wraps3), 16'd1);
    chk("plen3_seed6", 16'(period_len3), 16'd7);

    // Asynchronous reset between edges while a word is offered
    #4;
    reset_pseudo_random = 1'b0;
    #1;
    chk("async_valid3", 16'(rnd_valid3), 16'd0);
    chk("async_data3", 16'(rnd_data3), 16'd1);
    chk("async_valid8", 16'(rnd_valid8), 16'd0);
    chk("async_data8", 16'(rnd_data8), 16'd1);
    tick(); tick();
    reset_pseudo_random = 1'b1;
    base = acc3.size();
    wait_acc(base + 1, "post_reset_timeout");
    if (acc3.size() >= base + 1) chk("first_after_async", acc3[base], 16'd1);

    // Randomised traffic against the model
    repeat (3000) begin
      en        = ($urandom % 4) != 0;
      rnd_ready = ($urandom % 2) != 0;
      load      = ($urandom % 25) == 0;
      seed3     = 3'($urandom);
      seed8     = (($urandom % 3) == 0) ? 8'd0 : 8'($urandom);
      tick();
    end
    load = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
